// File: rtl/timer_ctrl.sv
// Command-driven controller for a prescaled WIDTH-bit up-counter. It supports
// one-shot and periodic modes and raises a registered one-cycle tick at each terminal count.
module timer_ctrl #(
    parameter int WIDTH = 8,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD_LIMIT = 2'd0;
    localparam logic [1:0] OP_LOAD_PRESC = 2'd1;
    localparam logic [1:0] OP_START      = 2'd2;
    localparam logic [1:0] OP_STOP       = 2'd3;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [PW-1:0]    presc_cnt_q, presc_cnt_d;
    logic             periodic_q, periodic_d;
    logic             tick_q, tick_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic             step;

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
    // are both high. cmd_ready is low for exactly the one cycle after each transfer.
    // The host keeps cmd_valid and its payload stable until the transfer happens.
    assign accept = cmd_valid & ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        limit_d     = limit_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        periodic_d  = periodic_q;
        tick_d      = 1'b0;
        ready_d     = 1'b1;
        step        = 1'b0;

        if (state_q == S_RUN) begin
            if (presc_cnt_q == presc_q) begin
                presc_cnt_d = '0;
                step        = 1'b1;
            end else begin
                presc_cnt_d = presc_cnt_q + PW'(1);
            end
        end

        // An accepted command overrides any step on the same edge. The step's
        // count, tick and state effects are dropped.
        if (accept) begin
            ready_d = 1'b0;
            case (cmd_op)
                OP_LOAD_LIMIT: limit_d = cmd_data;
                OP_LOAD_PRESC: begin
                    presc_d     = PW'(cmd_data);
                    presc_cnt_d = '0;
                end
                OP_START: begin
                    cnt_d       = '0;
                    presc_cnt_d = '0;
                    periodic_d  = cmd_data[0];
                    state_d     = S_RUN;
                end
                OP_STOP: state_d = S_IDLE;
            endcase
        end else if (step) begin
            if (cnt_q == limit_q) begin
                tick_d = 1'b1;
                if (periodic_q) begin
                    cnt_d = '0;
                end else begin
                    state_d = S_DONE;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            limit_q     <= '1;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            periodic_q  <= 1'b0;
            tick_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            limit_q     <= limit_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            periodic_q  <= periodic_d;
            tick_q      <= tick_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign cnt       = cnt_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign tick      = tick_q;
    assign dbg_state = state_q;

endmodule
